// File: rtl/request_issue_unit.sv
// request_issue_unit
//   Buffers upstream requests in a 2-entry holding buffer and presents them
//   one at a time to a downstream queue, holding each request stable until the
//   queue acknowledges it. A stall counter raises a sticky timeout flag when an
//   acknowledge takes too long.
//
// Ports
//   clk_in            : clock, rising edge
//   reset_n_in        : asynchronous active-low reset
//   flush_in          : synchronous discard of buffered and in-flight requests
//   in_request_in     : upstream payload
//   in_valid_in       : upstream payload valid
//   in_ready_out      : buffer can accept one entry this cycle
//   request_out       : registered payload to downstream queue
//   request_valid_out : registered payload valid to downstream queue
//   issue_ack_in      : downstream acceptance pulse (cycle after sampling)
//   is_empty_out      : buffer empty and no request presented
//   issued_count_out  : number of acknowledged requests (wraps)
//   timeout_err_out   : sticky stall-timeout flag
module request_issue_unit #(
  parameter int unsigned SINGLE_ENTRY_WIDTH_IN_BITS = 64,
  parameter int unsigned TIMEOUT_CYCLES             = 256,
  parameter int unsigned TIMEOUT_CNT_WIDTH          = 9
) (
  input  logic                                  clk_in,
  input  logic                                  reset_n_in,
  input  logic                                  flush_in,
  input  logic [SINGLE_ENTRY_WIDTH_IN_BITS-1:0] in_request_in,
  input  logic                                  in_valid_in,
  output logic                                  in_ready_out,
  output logic [SINGLE_ENTRY_WIDTH_IN_BITS-1:0] request_out,
  output logic                                  request_valid_out,
  input  logic                                  issue_ack_in,
  output logic                                  is_empty_out,
  output logic [15:0]                           issued_count_out,
  output logic                                  timeout_err_out
);

  typedef enum logic {
    ST_IDLE,
    ST_WAIT_ACK
  } state_e;

  localparam logic [TIMEOUT_CNT_WIDTH-1:0] TIMEOUT_VAL = TIMEOUT_CNT_WIDTH'(TIMEOUT_CYCLES);

  state_e                                state_q,   state_d;
  logic [SINGLE_ENTRY_WIDTH_IN_BITS-1:0] mem_q [2];
  logic [SINGLE_ENTRY_WIDTH_IN_BITS-1:0] mem_d [2];
  logic                                  wr_ptr_q,  wr_ptr_d;
  logic                                  rd_ptr_q,  rd_ptr_d;
  logic [1:0]                            count_q,   count_d;
  logic [SINGLE_ENTRY_WIDTH_IN_BITS-1:0] req_q,     req_d;
  logic                                  valid_q,   valid_d;
  logic [15:0]                           issued_q,  issued_d;
  logic [TIMEOUT_CNT_WIDTH-1:0]          stall_q,   stall_d;
  logic                                  timeout_q, timeout_d;

  logic push;
  logic ack_pop;

  assign in_ready_out      = (count_q != 2'd2) && !flush_in;
  assign push              = in_valid_in && in_ready_out;
  assign ack_pop           = (state_q == ST_WAIT_ACK) && issue_ack_in;

  assign request_out       = req_q;
  assign request_valid_out = valid_q;
  assign issued_count_out  = issued_q;
  assign timeout_err_out   = timeout_q;
  assign is_empty_out      = (count_q == 2'd0) && (state_q == ST_IDLE);

  always_comb begin
    state_d   = state_q;
    mem_d     = mem_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    req_d     = req_q;
    valid_d   = valid_q;
    issued_d  = issued_q;
    stall_d   = stall_q;
    // Flag follows the counter by one cycle and is not cleared by flush.
    timeout_d = timeout_q || (stall_q == TIMEOUT_VAL);

    if (flush_in) begin
      state_d  = ST_IDLE;
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
      count_d  = 2'd0;
      req_d    = '0;
      valid_d  = 1'b0;
      stall_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = in_request_in;
        wr_ptr_d        = ~wr_ptr_q;
      end
      if (ack_pop) begin
        rd_ptr_d = ~rd_ptr_q;
        issued_d = issued_q + 16'd1;
      end
      count_d = count_q + {1'b0, push} - {1'b0, ack_pop};

      // The presented entry stays in the buffer until acknowledged, so the
      // head is at rd_ptr_q and the follower (if any) at ~rd_ptr_q.
      case (state_q)
        ST_IDLE: begin
          if (count_q != 2'd0) begin
            req_d   = mem_q[rd_ptr_q];
            valid_d = 1'b1;
            stall_d = '0;
            state_d = ST_WAIT_ACK;
          end
        end
        ST_WAIT_ACK: begin
          if (issue_ack_in) begin
            stall_d = '0;
            if (count_q > 2'd1) begin
              req_d   = mem_q[~rd_ptr_q];
              valid_d = 1'b1;
            end else begin
              valid_d = 1'b0;
              state_d = ST_IDLE;
            end
          end else if (stall_q != TIMEOUT_VAL) begin
            stall_d = stall_q + 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      state_q   <= ST_IDLE;
      mem_q[0]  <= '0;
      mem_q[1]  <= '0;
      wr_ptr_q  <= 1'b0;
      rd_ptr_q  <= 1'b0;
      count_q   <= 2'd0;
      req_q     <= '0;
      valid_q   <= 1'b0;
      issued_q  <= '0;
      stall_q   <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      mem_q     <= mem_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      req_q     <= req_d;
      valid_q   <= valid_d;
      issued_q  <= issued_d;
      stall_q   <= stall_d;
      timeout_q <= timeout_d;
    end
  end

endmodule

// File: tb/tb_request_issue_unit.sv
module tb_request_issue_unit;

  localparam int unsigned W  = 16;
  localparam int unsigned TO = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          flush;
  logic [W-1:0]  in_req;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  req_out;
  logic          req_valid;
  logic          ack;
  logic          empty;
  logic [15:0]   issued;
  logic          timeout;

  int errors = 0;
  int checks = 0;

  // Reference model: a queue holding every accepted entry (presented head first)
  logic [W-1:0] mq[$];
  bit           m_pres;
  logic [W-1:0] m_req;
  int           m_stall;
  bit           m_to;
  int           m_issued;

  request_issue_unit #(
    .SINGLE_ENTRY_WIDTH_IN_BITS(W),
    .TIMEOUT_CYCLES(TO),
    .TIMEOUT_CNT_WIDTH(3)
  ) dut (
    .clk_in(clk),
    .reset_n_in(rst_n),
    .flush_in(flush),
    .in_request_in(in_req),
    .in_valid_in(in_valid),
    .in_ready_out(in_ready),
    .request_out(req_out),
    .request_valid_out(req_valid),
    .issue_ack_in(ack),
    .is_empty_out(empty),
    .issued_count_out(issued),
    .timeout_err_out(timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_pres   = 0;
    m_req    = '0;
    m_stall  = 0;
    m_to     = 0;
    m_issued = 0;
  endtask

  task automatic model_step(input bit v, input logic [W-1:0] d, input bit a, input bit f);
    bit rdy;
    rdy = (mq.size() != 2) && !f;
    if (m_stall == TO) m_to = 1;
    if (f) begin
      mq.delete();
      m_pres  = 0;
      m_req   = '0;
      m_stall = 0;
    end else begin
      if (m_pres && a) begin
        mq.delete(0);
        m_issued = (m_issued + 1) % 65536;
        m_stall  = 0;
        if (mq.size() > 0) m_req = mq[0];
        else m_pres = 0;
      end else if (m_pres) begin
        if (m_stall < TO) m_stall++;
      end else if (mq.size() > 0) begin
        m_req   = mq[0];
        m_pres  = 1;
        m_stall = 0;
      end
      if (v && rdy) mq.push_back(d);
    end
  endtask

  task automatic check_all();
    chk("valid",   32'(req_valid), 32'(m_pres));
    if (m_pres) chk("request", 32'(req_out), 32'(m_req));
    chk("ready",   32'(in_ready), 32'(mq.size() != 2));
    chk("empty",   32'(empty), 32'(mq.size() == 0 && !m_pres));
    chk("issued",  32'(issued), 32'(m_issued));
    chk("timeout", 32'(timeout), 32'(m_to));
  endtask

  // One clock: drive inputs, advance model at the edge, check on the falling edge
  task automatic step(input bit v, input logic [W-1:0] d, input bit a, input bit f);
    in_valid = v;
    in_req   = d;
    ack      = a;
    flush    = f;
    @(posedge clk);
    model_step(v, d, a, f);
    #1;
    in_valid = 0;
    in_req   = '0;
    ack      = 0;
    flush    = 0;
    @(negedge clk);
    check_all();
  endtask

  initial begin
    bit pend;
    logic [W-1:0] pdata;
    bit v, a, f;
    logic [W-1:0] d;

    rst_n = 0; flush = 0; in_req = '0; in_valid = 0; ack = 0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_valid",   32'(req_valid), 32'd0);
    chk("rst_request", 32'(req_out), 32'd0);
    chk("rst_ready",   32'(in_ready), 32'd1);
    chk("rst_empty",   32'(empty), 32'd1);
    chk("rst_issued",  32'(issued), 32'd0);
    chk("rst_timeout", 32'(timeout), 32'd0);
    rst_n = 1;

    // Single push, latency to valid, then ack
    step(1, 16'h00A5, 0, 0);
    chk("lat_t1_valid", 32'(req_valid), 32'd0);
    step(0, '0, 0, 0);
    chk("lat_t2_valid", 32'(req_valid), 32'd1);
    chk("lat_t2_req",   32'(req_out), 32'h00A5);
    step(0, '0, 1, 0);
    chk("lat_t4_valid", 32'(req_valid), 32'd0);
    chk("lat_issued",   32'(issued), 32'd1);

    // Back-to-back pushes of 1,2,3; ack the cycle after each presentation
    pend = 0;
    for (int i = 0; i < 12; i++) begin
      if (!pend && i < 3) begin pend = 1; pdata = 16'(i + 1); end
      a = m_pres && (m_stall == 1);
      v = pend;
      d = pend ? pdata : '0;
      if (pend && mq.size() != 2) pend = 0;
      step(v, d, a, 0);
    end
    chk("b2b_issued", 32'(issued), 32'd4);
    chk("b2b_empty",  32'(empty), 32'd1);

    // Ack while idle and empty is ignored
    step(0, '0, 1, 0);
    chk("idle_ack_issued", 32'(issued), 32'd4);

    // Stall timeout: present a request and withhold ack
    step(1, 16'h0077, 0, 0);
    for (int i = 0; i < 8; i++) step(0, '0, 0, 0);
    chk("to_flag", 32'(timeout), 32'd1);
    chk("to_req",  32'(req_out), 32'h0077);
    step(0, '0, 1, 0);
    chk("to_sticky", 32'(timeout), 32'd1);
    chk("to_popped", 32'(empty), 32'd1);

    // Full buffer, flush with coincident push and ack
    step(1, 16'h0011, 0, 0);
    step(1, 16'h0022, 0, 0);
    chk("full_ready", 32'(in_ready), 32'd0);
    step(1, 16'h0033, 1, 1);
    chk("flush_valid",  32'(req_valid), 32'd0);
    chk("flush_empty",  32'(empty), 32'd1);
    chk("flush_ready",  32'(in_ready), 32'd1);
    chk("flush_issued", 32'(issued), 32'd5);
    step(0, '0, 0, 0);

    // Asynchronous reset mid-WAIT_ACK with two entries held
    step(1, 16'h0044, 0, 0);
    step(1, 16'h0055, 0, 0);
    chk("pre_rst_valid", 32'(req_valid), 32'd1);
    #2 rst_n = 0;
    #1;
    model_reset();
    chk("arst_valid",   32'(req_valid), 32'd0);
    chk("arst_request", 32'(req_out), 32'd0);
    chk("arst_ready",   32'(in_ready), 32'd1);
    chk("arst_empty",   32'(empty), 32'd1);
    chk("arst_issued",  32'(issued), 32'd0);
    chk("arst_timeout", 32'(timeout), 32'd0);
    @(negedge clk);
    rst_n = 1;
    step(0, '0, 1, 0);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      v = ($urandom_range(0, 99) < 60);
      a = ($urandom_range(0, 99) < 45);
      f = ($urandom_range(0, 99) < 3);
      d = 16'($urandom);
      step(v, d, a, f);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
